// File: rtl/mem_arbiter.sv
// Two-port memory arbiter/sequencer: shares one SPRAM port between fetch (i_*) and load/store (d_*).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data always wins a tie.
module mem_arbiter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [15:0] i_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [15:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_data_in,
    output logic        mem_wr,
    output logic        mem_en,
    input  logic [31:0] mem_data_out,
    input  logic        mem_exception
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        port_q;
    logic        err_q;
    logic        i_rsp_valid_q, d_rsp_valid_q;
    logic        i_err_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        grantData, grantFetch, handshake, misaligned, accessErr;

`ifdef MEM_ARB_RR_EN
    logic        lastGrant_q;

    // On a tie, the port that did not win the previous handshake goes first.
    assign grantData = d_req_valid && (!i_req_valid || !lastGrant_q);
`else
    assign grantData = d_req_valid;
`endif
    assign grantFetch = i_req_valid && !grantData;
    assign handshake  = (state_q == IDLE) && (i_req_valid || d_req_valid);

    assign i_req_ready = (state_q == IDLE) && grantFetch;
    assign d_req_ready = (state_q == IDLE) && grantData;

    // Same alignment rule as the memory, so a bad store never reaches the write enables.
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            3'b010:  misaligned = (addr_q[1:0] != 2'b00);
            3'b011:  misaligned = 1'b1;
            3'b001:  misaligned = addr_q[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign accessErr = mem_exception || misaligned;

    assign mem_en      = (state_q == ACCESS);
    assign mem_wr      = (state_q == ACCESS) && wr_q && !misaligned;
    assign mem_addr    = addr_q;
    assign mem_size    = size_q;
    assign mem_data_in = wdata_q;

    assign i_rsp_valid = i_rsp_valid_q;
    assign i_rdata     = i_rdata_q;
    assign i_err       = i_err_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_err       = d_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = ACCESS;
            ACCESS:  state_d = wr_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            port_q        <= 1'b0;
            err_q         <= 1'b0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_err_q       <= 1'b0;
            d_err_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
`ifdef MEM_ARB_RR_EN
            lastGrant_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        port_q  <= grantData;
                        addr_q  <= grantData ? d_addr : i_addr;
                        size_q  <= grantData ? d_size : 3'b010;
                        wdata_q <= grantData ? d_wdata : 32'd0;
                        wr_q    <= grantData && d_wr;
`ifdef MEM_ARB_RR_EN
                        lastGrant_q <= grantData;
`endif
                    end
                end
                ACCESS: begin
                    err_q <= accessErr;
                    if (wr_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_err_q       <= accessErr;
                        d_rdata_q     <= 32'd0;
                    end
                end
                RESP: begin
                    // Address and size are still held, so the read decode is settled here.
                    if (port_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_err_q       <= err_q;
                        d_rdata_q     <= err_q ? 32'd0 : mem_data_out;
                    end else begin
                        i_rsp_valid_q <= 1'b1;
                        i_err_q       <= err_q;
                        i_rdata_q     <= err_q ? 32'd0 : mem_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a small behavioural memory; honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_ready;
    logic [15:0] i_addr = '0;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [15:0] d_addr = '0;
    logic        d_wr = 1'b0;
    logic [2:0]  d_size = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] mem_addr;
    logic [2:0]  mem_size;
    logic [31:0] mem_data_in;
    logic        mem_wr;
    logic        mem_en;
    logic [31:0] mem_data_out;
    logic        mem_exception;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycleCnt = 0;
    logic [7:0] memBytes [0:255];
    bit   memLoaded = 1'b0;

    mem_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wr(d_wr), .d_size(d_size), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_data_in(mem_data_in),
        .mem_wr(mem_wr), .mem_en(mem_en),
        .mem_data_out(mem_data_out), .mem_exception(mem_exception)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    // Memory model: little-endian bytes, combinational read decode, write on the clock edge.
    always @(posedge CLK) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) memBytes[i] <= 8'h00;
            memBytes[8'h10] <= 8'hEF; memBytes[8'h11] <= 8'hBE;
            memBytes[8'h12] <= 8'hAD; memBytes[8'h13] <= 8'hDE;
            memBytes[8'h40] <= 8'h44; memBytes[8'h41] <= 8'h33;
            memBytes[8'h42] <= 8'h22; memBytes[8'h43] <= 8'h11;
            memLoaded <= 1'b1;
        end else if (mem_en && mem_wr) begin
            memBytes[mem_addr[7:0]] <= mem_data_in[7:0];
            if (mem_size[1:0] != 2'b00) memBytes[mem_addr[7:0] + 8'd1] <= mem_data_in[15:8];
            if (mem_size[1:0] == 2'b10) begin
                memBytes[mem_addr[7:0] + 8'd2] <= mem_data_in[23:16];
                memBytes[mem_addr[7:0] + 8'd3] <= mem_data_in[31:24];
            end
        end
    end

    always_comb begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_data_out  = 32'd0;
        mem_exception = 1'b0;
        case (mem_size)
            3'b000: mem_data_out = {{24{memBytes[a][7]}}, memBytes[a]};
            3'b100: mem_data_out = {24'd0, memBytes[a]};
            3'b001: mem_data_out = {{16{memBytes[a + 8'd1][7]}}, memBytes[a + 8'd1], memBytes[a]};
            3'b101: mem_data_out = {16'd0, memBytes[a + 8'd1], memBytes[a]};
            3'b010: mem_data_out = {memBytes[a + 8'd3], memBytes[a + 8'd2], memBytes[a + 8'd1], memBytes[a]};
            default: mem_data_out = 32'd0;
        endcase
        if ((mem_size == 3'b010 && mem_addr[1:0] != 2'b00) || mem_size == 3'b011 ||
            (mem_size == 3'b001 && mem_addr[0]))
            mem_exception = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse pops the oldest expectation and is checked against it.
    initial begin
        rsp_t e;
        forever begin
            @(negedge CLK);
            if (i_rsp_valid || d_rsp_valid) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected response at cycle %0d: i=%0b d=%0b, expected none",
                             cycleCnt, i_rsp_valid, d_rsp_valid);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp port", {31'd0, d_rsp_valid}, {31'd0, e.port});
                    checkOutput("rsp cycle", cycleCnt, e.cyc);
                    checkOutput("rsp rdata", e.port ? d_rdata : i_rdata, e.data);
                    checkOutput("rsp err", {31'd0, e.port ? d_err : i_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic waitDrain();
        int t = 0;
        while (expQ.size() != 0 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL response timeout: %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input string name, input logic port, input logic [15:0] addr,
                                 input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input int lat,
                                 input logic expMemWr);
        int   t = 0;
        bit   got = 0;
        rsp_t e;
        @(posedge CLK); #1;
        if (port) begin
            d_req_valid = 1'b1; d_addr = addr; d_wr = wr; d_size = size; d_wdata = wdata;
        end else begin
            i_req_valid = 1'b1; i_addr = addr;
        end
        while (!got && t < 20) begin
            @(negedge CLK);
            got = port ? d_req_ready : i_req_ready;
            t++;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s handshake timeout: ready=0, expected 1", name);
        end else begin
            e.port = port; e.data = expData; e.err = expErr; e.cyc = cycleCnt + lat;
            expQ.push_back(e);
        end
        @(posedge CLK); #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge CLK);
        checkOutput({name, " mem_en@N+1"}, {31'd0, mem_en}, 32'd1);
        checkOutput({name, " mem_wr@N+1"}, {31'd0, mem_wr}, {31'd0, expMemWr});
        checkOutput({name, " mem_addr@N+1"}, {16'd0, mem_addr}, {16'd0, addr});
        @(negedge CLK);
        checkOutput({name, " mem_en@N+2"}, {31'd0, mem_en}, 32'd0);
        waitDrain();
    endtask

    task automatic resetDut();
        @(posedge CLK); #1;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        logic [3:0] expGrant;
        int t;
        bit got;
`ifdef MEM_ARB_RR_EN
        expGrant = 4'b0101;
`else
        expGrant = 4'b1111;
`endif
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        checkOutput("reset d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        checkOutput("reset i_rdata", i_rdata, 32'd0);
        checkOutput("reset d_rdata", d_rdata, 32'd0);
        checkOutput("reset errs", {30'd0, i_err, d_err}, 32'd0);
        checkOutput("reset mem_en/wr", {30'd0, mem_en, mem_wr}, 32'd0);
        checkOutput("reset mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("reset mem_size", {29'd0, mem_size}, 32'd0);
        checkOutput("reset mem_data_in", mem_data_in, 32'd0);
        RST_N = 1'b1;

        applyStimulus("fetch 0x10", 1'b0, 16'h0010, 1'b0, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        applyStimulus("store b 0x21", 1'b1, 16'h0021, 1'b1, 3'b000, 32'h000000F0, 32'd0, 1'b0, 2, 1'b1);
        applyStimulus("load b 0x21", 1'b1, 16'h0021, 1'b0, 3'b000, 32'd0, 32'hFFFFFFF0, 1'b0, 3, 1'b0);
        applyStimulus("load bu 0x21", 1'b1, 16'h0021, 1'b0, 3'b100, 32'd0, 32'h000000F0, 1'b0, 3, 1'b0);
        applyStimulus("store w 0x42", 1'b1, 16'h0042, 1'b1, 3'b010, 32'hCAFEF00D, 32'd0, 1'b1, 2, 1'b0);
        applyStimulus("load w 0x40", 1'b1, 16'h0040, 1'b0, 3'b010, 32'd0, 32'h11223344, 1'b0, 3, 1'b0);
        applyStimulus("fetch 0x12", 1'b0, 16'h0012, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 3, 1'b0);
        applyStimulus("load h 0x11", 1'b1, 16'h0011, 1'b0, 3'b001, 32'd0, 32'd0, 1'b1, 3, 1'b0);

        // Simultaneous requests from a fresh reset so the last-grant register starts at fetch.
        resetDut();
        @(posedge CLK); #1;
        i_req_valid = 1'b1; i_addr = 16'h0010;
        d_req_valid = 1'b1; d_addr = 16'h0040; d_wr = 1'b0; d_size = 3'b010;
        for (int k = 0; k < 4; k++) begin
            rsp_t e;
            t = 0;
            got = 0;
            while (!got && t < 20) begin
                @(negedge CLK);
                got = i_req_ready || d_req_ready;
                t++;
            end
            if (!got) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL tie grant %0d timeout: ready=0, expected 1", k);
            end else begin
                checkOutput($sformatf("tie grant %0d", k), {31'd0, d_req_ready}, {31'd0, expGrant[k]});
                e.port = expGrant[k];
                e.data = expGrant[k] ? 32'h11223344 : 32'hDEADBEEF;
                e.err  = 1'b0;
                e.cyc  = cycleCnt + 3;
                expQ.push_back(e);
            end
            @(posedge CLK);
        end
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        waitDrain();

        // Reset asserted while a fetch sits in RESP: the transaction must vanish.
        @(posedge CLK); #1;
        i_req_valid = 1'b1; i_addr = 16'h0010;
        t = 0;
        got = 0;
        while (!got && t < 20) begin
            @(negedge CLK);
            got = i_req_ready;
            t++;
        end
        checkOutput("rst-test handshake", {31'd0, got}, 32'd1);
        @(posedge CLK); #1;
        i_req_valid = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        checkOutput("rst mid mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("rst mid rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        checkOutput("rst mid mem_addr", {16'd0, mem_addr}, 32'd0);
        i_req_valid = 1'b1;
        #1;
        checkOutput("rst mid idle ready", {31'd0, i_req_ready}, 32'd1);
        i_req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        applyStimulus("fetch after rst", 1'b0, 16'h0010, 1'b0, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0, 3, 1'b0);

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the SPRAM-backed `memory` block. It shares the single memory port between the instruction-fetch requester and the load/store requester. It drives the memory's address, size, write data, `wr` and `en` lines, holds address and size stable while the memory's combinational read decode settles, and returns registered responses to each requester. It also pre-checks alignment so that a misaligned store never reaches the SPRAM write enables.

## Interface
Parameters:
- none; address width is fixed at 16 bits and data width at 32 bits, matching `memory`.

Ports:
- `CLK` input 1: single clock for the whole block.
- `RST_N` input 1: reset; asynchronous, active-low.
- `i_req_valid` input 1: fetch request.
- `i_req_ready` output 1: fetch request accepted this cycle.
- `i_addr` input 16: fetch byte address; size is always word (3'b010).
- `i_rsp_valid` output 1: one-cycle pulse; `i_rdata` and `i_err` are valid.
- `i_rdata` output 32: fetched word.
- `i_err` output 1: misaligned fetch.
- `d_req_valid` input 1: load/store request.
- `d_req_ready` output 1: load/store request accepted this cycle.
- `d_addr` input 16: byte address.
- `d_wr` input 1: 1 = store, 0 = load.
- `d_size` input 3: memory size code: 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- `d_wdata` input 32: store data, right-aligned.
- `d_rsp_valid` output 1: one-cycle pulse for both loads and stores.
- `d_rdata` output 32: load data; 0 for stores.
- `d_err` output 1: alignment or size exception.
- `mem_addr` output 16: to `memory.addr`.
- `mem_size` output 3: to `memory.size`.
- `mem_data_in` output 32: to `memory.data_in`.
- `mem_wr` output 1: to `memory.wr`.
- `mem_en` output 1: to `memory.en`.
- `mem_data_out` input 32: from `memory.data_out`.
- `mem_exception` input 1: from `memory.exception`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `*_req_valid` is high, the winner's `*_req_ready` is driven high combinationally in the same cycle. The loser's ready is 0.
  - The winner's addr, size, wdata and wr, plus the port id, are latched. Next state is ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_en` = 1; `mem_addr` and `mem_size` come from the latched values.
  - `mem_wr` = latched wr AND NOT `misaligned`.
  - `misaligned` is computed locally with the same rule as the memory:
    - size 010 with addr[1:0] ≠ 0;
    - size 011;
    - size 001 with addr[0] = 1.
  - `mem_exception` is sampled into the error register.
  - Store → the response pulses next cycle, then IDLE. Load → RESP.
- **RESP**
  - `mem_en` = 0, `mem_wr` = 0.
  - `mem_addr` and `mem_size` are held, because the memory's read decode depends on them combinationally.
  - `mem_data_out` is captured into the owning port's rdata register; the response pulses next cycle; next state is IDLE.
- **Arbitration**
  - Fixed data priority unless `MEM_ARB_RR_EN` is defined (see Configuration).
- **Outputs and flags**
  - `mem_data_in` = latched wdata in every state.
  - `*_rdata` holds its last value between pulses.
  - On an erroring load, `*_rdata` = 0.
  - `*_err` is meaningful only while `*_rsp_valid` is high.
- `*_req_ready` is 0 in ACCESS and RESP; one transaction is outstanding at a time.

## Timing
- Handshake in cycle N (valid & ready) → ACCESS in N+1 → store response at N+2; load RESP at N+2 → load response at N+3.
- Back-to-back throughput:
  - store: one per 2 cycles;
  - load: one per 3 cycles.
  - A new request may be accepted in the same cycle as the previous response pulse, because the FSM is back in IDLE then.
- Requesters must hold valid and payload until ready; the payload is sampled only on the handshake cycle.
- Reset values:
  - state = IDLE;
  - all `*_rsp_valid`, `*_err` = 0;
  - `*_rdata` = 0;
  - `mem_en`, `mem_wr` = 0;
  - `mem_addr`, `mem_size`, `mem_data_in` = 0;
  - last-grant = fetch.
- Reset asserted mid-transaction:
  - outputs go to reset values immediately (asynchronous);
  - the transaction is dropped with no response;
  - a store in ACCESS whose clock edge has not yet occurred is not written.
- Request valid deasserted in the same cycle that ready rises: no handshake, and the state stays IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - round-robin on simultaneous requests, using the last-grant register (updated on every handshake);
  - the port not granted last wins.
  - Because last-grant resets to fetch, the first simultaneous request goes to data.
- Not defined:
  - data port always wins on a tie;
  - last-grant register is not built.
- In both configurations a lone requester is granted immediately.

## Test plan
- **Aligned load.** Preload word 0x0010 = 0xDEADBEEF; fetch 0x0010.
  - Required: handshake at N, `mem_en` high at N+1 only, `i_rsp_valid` at N+3 with `i_rdata` = 0xDEADBEEF and `i_err` = 0.
- **Byte store then signed load.** Store size 000, addr 0x0021, wdata 0x000000F0; then load size 000 at 0x0021.
  - Required: `d_rsp_valid` at N+2 with `d_err` = 0; the load then returns 0xFFFFFFF0.
  - Load size 100 at the same address returns 0x000000F0.
- **Misaligned store.** Word store to 0x0042.
  - Required: `mem_wr` stays 0, `d_err` = 1 at N+2, and word 0x0040 is unchanged on readback.
- **Simultaneous requests.** Both ports valid continuously for 4 transactions.
  - Without `MEM_ARB_RR_EN`: grants are D, D, D, D.
  - With it: grants are D, I, D, I.
- **Reset during load.** Deassert `RST_N` in the RESP cycle.
  - Required: `mem_en` = 0, no `*_rsp_valid` pulse, and the FSM in IDLE.
  - A new fetch after reset release completes normally at N+3.
